e_mem_bot_port_ctrl: RTL

E_MEM_BOT_PORT_CTRL -- requirements
Module: e_mem_bot_port_ctrl

---
 rtl/e_mem_bot_port_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/e_mem_bot_port_ctrl.sv
// Round-robin funnel of NUM_CH request channels onto one memory port; one access per cycle.
// Read response RD_LAT+2 cycles after acceptance; ready is combinational, non-granted channels stall.
module e_mem_bot_port_ctrl #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                     UserCLK,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_req_valid,
  output logic [NUM_CH-1:0]        ch_req_ready,
  input  logic [NUM_CH-1:0]        ch_req_we,
  input  logic [NUM_CH*ADDR_W-1:0] ch_req_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_req_wdata,
  output logic [NUM_CH-1:0]        ch_resp_valid,
  output logic [DATA_W-1:0]        ch_resp_data,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PW-1:0] LAST = PW'(NUM_CH - 1);
  localparam logic [PW:0] NCH = (PW + 1)'(NUM_CH);

  logic [PW-1:0]     ptr;
  logic [PW-1:0]     grant;
  logic              grant_vld;
  logic [PW:0]       sum;
  logic [PW-1:0]     idx;
  logic [PW-1:0]     mem_ch;
  logic [RD_LAT-1:0] tag_vld;
  logic [PW-1:0]     tag_ch [RD_LAT];
  logic              pend_vld;
  logic [PW-1:0]     pend_ch;
  logic [DATA_W-1:0] rdata_q;

  // Scan upward from ptr with wrap; first valid channel wins.
  always_comb begin
    grant_vld    = 1'b0;
    grant        = '0;
    sum          = '0;
    idx          = '0;
    ch_req_ready = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum = {1'b0, ptr} + (PW + 1)'(k);
      if (sum >= NCH) sum = sum - NCH;
      idx = sum[PW-1:0];
      if (!grant_vld && ch_req_valid[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
    if (grant_vld) ch_req_ready = NUM_CH'(1) << grant;
  end

  always_ff @(posedge UserCLK or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_ch    <= '0;
    end else begin
      mem_en <= grant_vld;
      if (grant_vld) begin
        ptr       <= (grant == LAST) ? '0 : grant + 1'b1;
        mem_we    <= ch_req_we[grant];
        mem_addr  <= ch_req_addr[int'(grant)*ADDR_W +: ADDR_W];
        mem_wdata <= ch_req_wdata[int'(grant)*DATA_W +: DATA_W];
        mem_ch    <= grant;
      end
    end
  end

  // Tag follows the read through the memory latency; data is staged so it changes together with valid.
  always_ff @(posedge UserCLK or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_ch[i] <= '0;
      pend_vld      <= 1'b0;
      pend_ch       <= '0;
      rdata_q       <= '0;
      ch_resp_valid <= '0;
      ch_resp_data  <= '0;
    end else begin
      tag_vld[0] <= mem_en & ~mem_we;
      tag_ch[0]  <= mem_ch;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_ch[i]  <= tag_ch[i-1];
      end
      pend_vld <= tag_vld[RD_LAT-1];
      if (tag_vld[RD_LAT-1]) begin
        rdata_q <= mem_rdata;
        pend_ch <= tag_ch[RD_LAT-1];
      end
      ch_resp_valid <= pend_vld ? (NUM_CH'(1) << pend_ch) : '0;
      if (pend_vld) ch_resp_data <= rdata_q;
    end
  end

endmodule
